// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: radix-2 iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO write path.
// Latency: start accepted in cycle 0, hilo_we in cycle WIDTH+2 (cycle 1 for MULT/MULTU with MULDIV_FAST_MUL_EN).
// Backpressure: busy stalls the pipeline from the issue cycle through DONE; flush aborts and suppresses the write.
`timescale 1ns/1ps
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 hilo_we,
    output logic [2*WIDTH-1:0]   hilo_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]         state;
    logic [5:0]         cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               accept;
    logic               op_signed;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   abs_a_in;
    logic [WIDTH-1:0]   abs_b_in;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   orig_a;
    logic [2*WIDTH-1:0] result;

    // Issue decode: magnitudes and signs of the incoming operands, plus the combined stall.
    always_comb begin
        accept    = (state == S_IDLE) && start && !flush;
        op_signed = ~op[0];
        neg_a_in  = op_signed & src_a[WIDTH-1];
        neg_b_in  = op_signed & src_b[WIDTH-1];
        abs_a_in  = neg_a_in ? (~src_a + 1'b1) : src_a;
        abs_b_in  = neg_b_in ? (~src_b + 1'b1) : src_b;
        busy      = (state != S_IDLE) || accept;
        // Reset or flush in the DONE cycle must swallow the strobe.
        hilo_we   = (state == S_DONE) && !flush && !rst;
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, mag_b};
    end

    // Sign correction and HI/LO packing; a zero divisor returns the raw dividend and all-ones.
    always_comb begin
        prod_raw = {acc_hi, acc_lo};
        prod_fix = (sign_a ^ sign_b) ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = (sign_a ^ sign_b) ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = sign_a ? (~acc_hi + 1'b1) : acc_hi;
        orig_a   = sign_a ? (~mag_a + 1'b1) : mag_a;
        if (!is_div)
            result = prod_fix;
        else if (mag_b == '0)
            result = {orig_a, {WIDTH{1'b1}}};
        else
            result = {rem_fix, quo_fix};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;

    // Single-cycle array product; sign-extending to full width makes one multiplier serve both signednesses.
    always_comb begin
        fast_prod = {{WIDTH{neg_a_in}} | {WIDTH{1'b0}}, src_a} * {{WIDTH{op_signed & src_b[WIDTH-1]}}, src_b};
        fast_prod = {{WIDTH{op_signed & src_a[WIDTH-1]}}, src_a} * {{WIDTH{op_signed & src_b[WIDTH-1]}}, src_b};
    end
`endif

    // Sequencer: IDLE -> CALC (WIDTH steps) -> FIX -> DONE, flush returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            hilo_out <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        is_div <= op[1];
                        sign_a <= neg_a_in;
                        sign_b <= neg_b_in;
                        mag_a  <= abs_a_in;
                        mag_b  <= abs_b_in;
                        acc_hi <= '0;
                        // Multiply consumes the multiplier from acc_lo; divide shifts the dividend out of it.
                        acc_lo <= op[1] ? abs_a_in : abs_b_in;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op[1]) begin
                            hilo_out <= fast_prod;
                            state    <= S_DONE;
                        end else begin
                            state    <= S_CALC;
                        end
`else
                        state <= S_CALC;
`endif
                    end
                end
                S_CALC: begin
                    if (!is_div) begin
                        {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
                    end else if (!rem_diff[WIDTH]) begin
                        acc_hi <= rem_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= rem_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_ITER)
                        state <= S_FIX;
                end
                S_FIX: begin
                    hilo_out <= result;
                    state    <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
